// File: rtl/mul_seq_32.sv
// Sequential 32x32 -> 64 multiplier (shift-and-add, one partial product per cycle).
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   start_valid  a, b and is_signed are presented
//   start_ready  block is idle and will accept a new operation
//   a, b         32-bit multiplicand / multiplier
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   res_valid    product is valid (held until res_ready)
//   res_ready    consumer takes the product
//   product      64-bit result, written once per operation
//   busy         high whenever the block is not idle
//
// Signed operands are reduced to magnitudes at accept time, multiplied
// unsigned over 32 CALC cycles, and the sign is reapplied in one FIX cycle.

// 4-bit carry-lookahead block: internal carries from explicit lookahead
// equations plus group generate/propagate for the next lookahead level.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       grp_g,
  output logic       grp_p
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign sum   = p ^ c;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
endmodule

// W-bit carry-lookahead adder built from 4-bit lookahead blocks.
module cla_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int N = W / 4;

  logic [N-1:0] grp_g;
  logic [N-1:0] grp_p;
  logic [N:0]   carry;

  // Group generate/propagate depend only on a and b, so the block carries
  // resolve without any combinational loop through the sum logic.
  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = grp_g[i] | (grp_p[i] & carry[i]);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_blk
    cla4 u_cla4 (
      .a     (a[4*i +: 4]),
      .b     (b[4*i +: 4]),
      .cin   (carry[i]),
      .sum   (sum[4*i +: 4]),
      .grp_g (grp_g[i]),
      .grp_p (grp_p[i])
    );
  end

  assign cout = carry[N];
endmodule

module mul_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  count;
  logic        neg;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] add_b;
  logic [31:0] calc_sum;
  logic        calc_cout;
  logic [63:0] neg_in;
  logic [63:0] neg_sum;
  logic        neg_cout_unused;

  // 32'h8000_0000 negates to itself, which read as unsigned is exactly 2^31.
  assign a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;

  // Adding zero when the multiplier bit is clear yields {0, hi}.
  assign add_b = lo[0] ? mcand : 32'd0;

  cla_adder #(.W(32)) u_calc_add (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (calc_sum),
    .cout (calc_cout)
  );

  // Two's-complement negation as ~x + 1.
  assign neg_in = ~{hi, lo};

  cla_adder #(.W(64)) u_fix_neg (
    .a    (neg_in),
    .b    (64'd0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_valid) state_next = CALC;
      // count holds the number of CALC cycles already completed.
      CALC: if (count == 6'd31) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift-add in CALC, sign fix-up into product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand <= a_mag;
            lo    <= b_mag;
            hi    <= '0;
            count <= '0;
            neg   <= is_signed & (a[31] ^ b[31]);
          end
        end
        CALC: begin
          {hi, lo} <= {calc_cout, calc_sum, lo[31:1]};
          count    <= count + 6'd1;
        end
        FIX: begin
          product <= neg ? neg_sum : {hi, lo};
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: directed vector table, handshake and
// reset sequences, then randomized operations against a plain-arithmetic model.
// Latency is counted in rising edges with the accept edge as edge 1.
module tb_mul_seq_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_signed = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] product;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  localparam int LATENCY = 34;
  localparam int WAIT_LIMIT = 80;
  localparam int RANDOM_OPS = 1800;

  mul_seq_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] expected;
  } vec_t;

  // Reference: exact 64-bit product from ordinary arithmetic.
  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at a falling edge; presents an operation for exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x;
    b = y;
    is_signed = s;
    start_valid = 1'b1;
    checkOutput("start_ready before accept", {63'd0, start_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Counts edges until res_valid; a hang is reported through the latency check
  // and the DUT is reset so later checks start from a known state.
  task automatic waitResult(input int start_lat, output logic [63:0] prod, output int lat);
    lat = start_lat;
    while (!res_valid && lat < WAIT_LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    prod = product;
    checkOutput("latency", 64'(lat), 64'(LATENCY));
    if (!res_valid) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic retire(input int stall);
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        table_v[$];
    logic [63:0] prod;
    logic [63:0] held;
    int          lat;

    table_v.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    table_v.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    table_v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    table_v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
    table_v.push_back('{32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 64'h0000_0000_0000_0000});
    table_v.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    table_v.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001});
    table_v.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
    table_v.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000});
    table_v.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE});

    // Reset values are visible before any clock edge.
    #2;
    checkOutput("reset start_ready", {63'd0, start_ready}, 64'd1);
    checkOutput("reset res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset product", product, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; the first entry is accepted on the first edge after reset.
    for (int i = 0; i < table_v.size(); i++) begin
      applyStimulus(table_v[i].a, table_v[i].b, table_v[i].s);
      waitResult(1, prod, lat);
      checkOutput($sformatf("table[%0d] product", i), prod, table_v[i].expected);
      retire(1);
    end

    // Handshake: start pulses during CALC are ignored, result held under stall.
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    lat = 1;
    repeat (4) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    a = 32'd3;
    b = 32'd3;
    start_valid = 1'b1;
    checkOutput("start_ready in CALC", {63'd0, start_ready}, 64'd0);
    checkOutput("busy in CALC", {63'd0, busy}, 64'd1);
    repeat (2) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start_valid = 1'b0;
    waitResult(lat, held, lat);
    checkOutput("handshake product", held, refProduct(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("stall %0d res_valid", k), {63'd0, res_valid}, 64'd1);
      checkOutput($sformatf("stall %0d product", k), product, held);
    end
    // Start offered on the DONE->IDLE edge must not be taken.
    a = 32'd5;
    b = 32'd5;
    start_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    res_ready = 1'b0;
    checkOutput("idle after release busy", {63'd0, busy}, 64'd0);
    checkOutput("idle after release start_ready", {63'd0, start_ready}, 64'd1);
    checkOutput("idle after release res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("product retained in IDLE", product, held);
    res_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b0;
    checkOutput("no queued start busy", {63'd0, busy}, 64'd0);

    // Reset around CALC iteration 15 acts without a clock edge.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-CALC reset busy", {63'd0, busy}, 64'd0);
    checkOutput("mid-CALC reset start_ready", {63'd0, start_ready}, 64'd1);
    checkOutput("mid-CALC reset res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("mid-CALC reset product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd0, 32'd12345, 1'b0);
    waitResult(1, prod, lat);
    checkOutput("post-reset 0*12345", prod, 64'd0);
    retire(0);

    // Reset while DONE drops the result.
    applyStimulus(32'd6, 32'd7, 1'b0);
    waitResult(1, prod, lat);
    checkOutput("pre-reset 6*7", prod, 64'd42);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("DONE reset res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("DONE reset product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("DONE reset stays idle", {63'd0, busy}, 64'd0);

    // Randomized operations with random consumer stalls.
    for (int n = 0; n < RANDOM_OPS; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      ra = pickOperand();
      rb = pickOperand();
      rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rs);
      waitResult(1, prod, lat);
      checkOutput($sformatf("random %0d %h*%h s=%0d", n, ra, rb, rs), prod,
                  refProduct(ra, rb, rs));
      retire($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
